controlador_estacionamiento_param: RTL
======================================

Name: controlador_estacionamiento_param

Overview:
Parametrised next-generation gate controller for the parking entrance.
- Accepts a multi-word PIN entered serially, one word per sEnter strobe.
- Counts wrong attempts against a configurable limit and detects tailgating.
- Tracks lot occupancy against a configured capacity.
- Sits between the entrance/exit sensors, keypad and gate actuator, and drives the alarm outputs.

Parameters:
CODE_W, 8, width of one keypad code word.
N_PALABRAS, 2, code words per PIN.
PIN, 16'h0263, correct PIN, CODE_W*N_PALABRAS bits; first word entered occupies the MSBs.
MAX_INTENTOS, 3, consecutive wrong PINs that raise sAlmInc.
CAPACIDAD, 16, parking spaces.
OCC_W, 5, occupancy counter width; must satisfy 2^OCC_W > CAPACIDAD.
T_ABIERTO, 8, cycles the gate stays open waiting for sSalida before auto-closing.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
sEntrada  input  1  vehicle present at entrance sensor (level)
sSalida  input  1  vehicle crossed the gate sensor (level)
sRetiro  input  1  single-cycle pulse: a vehicle left the lot
sEnter  input  1  single-cycle strobe: sCode is valid
sCode  input  CODE_W  keypad word
sAbrir  output  1  gate open command
sCerrar  output  1  gate close command
sBloq  output  1  gate locked
sAlmInc  output  1  wrong-PIN alarm
sAlmBloq  output  1  tailgating/lock alarm
sLleno  output  1  lot full
sOcupacion  output  OCC_W  current occupancy

Behaviour:
Reset and outputs
- Reset (reset=0, asynchronous): state ESPERA; word counter, intentos, timer, occupancy = 0.
- Reset output values: sAbrir=0, sCerrar=1, sBloq=0, sAlmInc=0, sAlmBloq=0, sLleno=0, sOcupacion=0.
- Reset mid-operation aborts everything and returns to these values.
- Moore outputs: sAbrir=1 only in ABIERTO; sCerrar = not sAbrir; sBloq = sAlmBloq = 1 only in BLOQUEO.
- sAlmInc is a registered flag. sLleno = (occupancy == CAPACIDAD). sOcupacion is the registered counter.

PIN assembly (INGRESO and BLOQUEO only)
- Each sEnter shifts sCode into a CODE_W*N_PALABRAS register and increments the word counter.
- On the N_PALABRAS-th sEnter, compare {previous words, current sCode} with PIN in that same cycle; the result takes effect at the next edge.
- The word counter then clears.
- sEnter in ESPERA or ABIERTO is ignored.

State ESPERA
- sEntrada=1 and not sLleno -> INGRESO, word counter cleared.
- sEntrada=1 while sLleno=1 -> stay in ESPERA.

State INGRESO
- Correct PIN -> ABIERTO; intentos=0; sAlmInc=0; timer=0.
- Wrong PIN -> stay in INGRESO; intentos increments, saturating at MAX_INTENTOS; sAlmInc=1 when the new intentos value >= MAX_INTENTOS.
- sEntrada=0 with no completing sEnter -> ESPERA; partial PIN discarded; intentos and sAlmInc retained.

State ABIERTO
- Timer increments every cycle.
- sSalida=1, sEntrada=0 -> ESPERA; occupancy +1.
- sSalida=1, sEntrada=1 in the same cycle (tailgating) -> BLOQUEO; occupancy +1.
- Timer == T_ABIERTO-1 with sSalida=0 -> ESPERA; occupancy unchanged.

State BLOQUEO
- Exit only on a correct PIN -> ESPERA (gate stays closed); intentos=0; sAlmInc=0.
- Wrong PIN -> stay in BLOQUEO; intentos unchanged.
- sEntrada and sSalida are ignored.

Occupancy
- Increment and sRetiro in the same cycle -> occupancy unchanged.
- sRetiro at 0 is ignored.
- Increment saturates at CAPACIDAD.
- sLleno updates the cycle after the counter changes.

Test Plan:
- Reset, sEntrada=1, sEnter with 8'h02 then 8'h63 -> sAbrir=1 the cycle after the second strobe; then sSalida=1 -> sAbrir=0, sCerrar=1, sOcupacion=1.
- In INGRESO, three wrong PINs (8'h11,8'h22 each) -> sAlmInc=1 after the third; then correct PIN -> sAbrir=1, sAlmInc=0.
- Gate open, sSalida and sEntrada both 1 in the same cycle -> sBloq=1, sAlmBloq=1, sOcupacion+1; wrong PIN keeps the lock; 02,63 -> ESPERA, sBloq=0, sAbrir=0.
- Open gate, no sSalida for 8 cycles -> sAbrir drops after the 8th cycle; sOcupacion unchanged.
- Fill to 16 -> sLleno=1 and sEntrada does not leave ESPERA; sRetiro pulse -> sOcupacion=15, sLleno=0; sRetiro coincident with an entry increment -> count unchanged.
- Assert reset=0 asynchronously mid-PIN and while ABIERTO -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/controlador_estacionamiento_param_if.sv
// Parking gate controller bus: sensors and keypad in, gate and alarm commands out.
interface controlador_estacionamiento_param_if #(
  parameter int CODE_W = 8,
  parameter int OCC_W  = 5
);
  logic              sEntrada;
  logic              sSalida;
  logic              sRetiro;
  logic              sEnter;
  logic [CODE_W-1:0] sCode;
  logic              sAbrir;
  logic              sCerrar;
  logic              sBloq;
  logic              sAlmInc;
  logic              sAlmBloq;
  logic              sLleno;
  logic [OCC_W-1:0]  sOcupacion;

  // Environment side: drives sensors/keypad, observes gate and alarms
  modport master (
    output sEntrada, sSalida, sRetiro, sEnter, sCode,
    input  sAbrir, sCerrar, sBloq, sAlmInc, sAlmBloq, sLleno, sOcupacion
  );

  // Controller side
  modport slave (
    input  sEntrada, sSalida, sRetiro, sEnter, sCode,
    output sAbrir, sCerrar, sBloq, sAlmInc, sAlmBloq, sLleno, sOcupacion
  );
endinterface

// File: rtl/controlador_estacionamiento_param.sv
// Parking entrance gate controller: serial multi-word PIN entry, wrong-attempt
// alarm, tailgating lock, auto-close timer and lot occupancy tracking.
module controlador_estacionamiento_param #(
  parameter int                             CODE_W       = 8,
  parameter int                             N_PALABRAS   = 2,
  parameter logic [CODE_W*N_PALABRAS-1:0]   PIN          = 16'h0263,
  parameter int                             MAX_INTENTOS = 3,
  parameter int                             CAPACIDAD    = 16,
  parameter int                             OCC_W        = 5,
  parameter int                             T_ABIERTO    = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  controlador_estacionamiento_param_if.slave bus
);

  localparam int PIN_W = CODE_W * N_PALABRAS;
  localparam int WC_W  = (N_PALABRAS > 1) ? $clog2(N_PALABRAS) : 1;
  localparam int INT_W = $clog2(MAX_INTENTOS + 1);
  localparam int TMR_W = (T_ABIERTO > 1) ? $clog2(T_ABIERTO) : 1;

  typedef enum logic [1:0] {ESPERA, INGRESO, ABIERTO, BLOQUEO} estado_t;

  estado_t           state, stateNext;
  logic [WC_W-1:0]   wordCnt, wordCntNext;
  logic [PIN_W-1:0]  pinReg, pinRegNext;
  logic [INT_W-1:0]  intentos, intentosNext;
  logic              almInc, almIncNext;
  logic [TMR_W-1:0]  timer, timerNext;
  logic [OCC_W-1:0]  ocup, ocupNext;
  logic              ocupInc;
  logic              lleno;

  // PIN assembly: the word being strobed now is appended below the stored ones
  logic [PIN_W-1:0]  pinCand;
  logic              pinActive;
  logic              pinDone;
  logic              pinOk;

  assign pinCand   = (pinReg << CODE_W) | PIN_W'(bus.sCode);
  assign pinActive = (state == INGRESO) || (state == BLOQUEO);
  assign pinDone   = pinActive && bus.sEnter && (wordCnt == WC_W'(N_PALABRAS - 1));
  assign pinOk     = pinDone && (pinCand == PIN);

  assign lleno = (ocup == OCC_W'(CAPACIDAD));

  // State and datapath registers; reset drops everything immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ESPERA;
      wordCnt  <= '0;
      pinReg   <= '0;
      intentos <= '0;
      almInc   <= 1'b0;
      timer    <= '0;
      ocup     <= '0;
    end else begin
      state    <= stateNext;
      wordCnt  <= wordCntNext;
      pinReg   <= pinRegNext;
      intentos <= intentosNext;
      almInc   <= almIncNext;
      timer    <= timerNext;
      ocup     <= ocupNext;
    end
  end

  // Next-state logic: gate sequencing, PIN evaluation, attempt counting, timer
  always_comb begin
    stateNext    = state;
    wordCntNext  = wordCnt;
    pinRegNext   = pinReg;
    intentosNext = intentos;
    almIncNext   = almInc;
    timerNext    = timer;
    ocupInc      = 1'b0;
    case (state)
      ESPERA: begin
        // A full lot keeps the gate idle even with a car waiting
        if (bus.sEntrada && !lleno) begin
          stateNext   = INGRESO;
          wordCntNext = '0;
        end
      end
      INGRESO: begin
        if (pinDone) begin
          wordCntNext = '0;
          pinRegNext  = pinCand;
          if (pinOk) begin
            stateNext    = ABIERTO;
            intentosNext = '0;
            almIncNext   = 1'b0;
            timerNext    = '0;
          end else begin
            if (intentos < INT_W'(MAX_INTENTOS))
              intentosNext = intentos + INT_W'(1);
            almIncNext = (intentosNext >= INT_W'(MAX_INTENTOS));
          end
        end else begin
          if (bus.sEnter) begin
            pinRegNext  = pinCand;
            wordCntNext = wordCnt + WC_W'(1);
          end
          // Driver backed away: drop the partial PIN, keep the attempt history
          if (!bus.sEntrada) begin
            stateNext   = ESPERA;
            wordCntNext = '0;
          end
        end
      end
      ABIERTO: begin
        timerNext = timer + TMR_W'(1);
        if (bus.sSalida) begin
          ocupInc     = 1'b1;
          wordCntNext = '0;
          // A second car already at the sensor means it is following through
          stateNext   = bus.sEntrada ? BLOQUEO : ESPERA;
        end else if (timer == TMR_W'(T_ABIERTO - 1)) begin
          stateNext = ESPERA;
        end
      end
      BLOQUEO: begin
        // Only a correct PIN clears the lock; wrong ones do not count as attempts
        if (pinDone) begin
          wordCntNext = '0;
          pinRegNext  = pinCand;
          if (pinOk) begin
            stateNext    = ESPERA;
            intentosNext = '0;
            almIncNext   = 1'b0;
          end
        end else if (bus.sEnter) begin
          pinRegNext  = pinCand;
          wordCntNext = wordCnt + WC_W'(1);
        end
      end
      default: stateNext = ESPERA;
    endcase
  end

  // Occupancy: entry and departure in the same cycle cancel out
  always_comb begin
    ocupNext = ocup;
    if (ocupInc && bus.sRetiro)
      ocupNext = ocup;
    else if (ocupInc) begin
      if (!lleno)
        ocupNext = ocup + OCC_W'(1);
    end else if (bus.sRetiro && (ocup != '0))
      ocupNext = ocup - OCC_W'(1);
  end

  assign bus.sAbrir     = (state == ABIERTO);
  assign bus.sCerrar    = (state != ABIERTO);
  assign bus.sBloq      = (state == BLOQUEO);
  assign bus.sAlmBloq   = (state == BLOQUEO);
  assign bus.sAlmInc    = almInc;
  assign bus.sLleno     = lleno;
  assign bus.sOcupacion = ocup;

endmodule
